key_event_decoder: RTL and testbench

KEY_EVENT_DECODER -- requirements
Module: key_event_decoder

---
 rtl/key_pkg.sv | 14 +
 rtl/key_event_decoder.sv | 113 +++++++++++
 tb/tb_key_event_decoder.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/key_pkg.sv
// Shared constants and state encoding for the key event decoder.
package key_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    PRESSED = 2'b01,
    HELD    = 2'b10
  } key_state_t;

  localparam int unsigned KEY_LONG_CYCLES   = 100000000;
  localparam int unsigned KEY_REPEAT_CYCLES = 20000000;
  localparam int unsigned KEY_CW            = 27;

endpackage

// File: rtl/key_event_decoder.sv
// Press / release / long-press / auto-repeat event decoder for a debounced key.
// Auto-repeat is built only when KEY_REPEAT_EN is defined; otherwise repeat_tick is 0.
module key_event_decoder
  import key_pkg::*;
#(
  parameter int unsigned LONG_CYCLES   = KEY_LONG_CYCLES,
  parameter int unsigned REPEAT_CYCLES = KEY_REPEAT_CYCLES,
  parameter int unsigned CW            = KEY_CW
) (
  input  logic reloj,
  input  logic resetM,
  input  logic sw_db,
  output logic press_tick,
  output logic release_tick,
  output logic long_tick,
  output logic repeat_tick,
  output logic held
);

  if (LONG_CYCLES < 2 || REPEAT_CYCLES < 2 ||
      ((LONG_CYCLES - 1) >> CW) != 0 || ((REPEAT_CYCLES - 1) >> CW) != 0) begin : g_bad_params
    $error("key_event_decoder: cycle counts must be >= 2 and fit in CW bits");
  end

  localparam logic [CW-1:0] LONG_LAST = CW'(LONG_CYCLES - 1);

  key_state_t    r_state;
  logic [CW-1:0] r_cnt;
  logic          r_press;
  logic          r_release;
  logic          r_long;
  logic          r_held;

`ifdef KEY_REPEAT_EN
  localparam logic [CW-1:0] REPEAT_LAST = CW'(REPEAT_CYCLES - 1);
  logic r_repeat;
  assign repeat_tick = r_repeat;
`else
  assign repeat_tick = 1'b0;
`endif

  assign press_tick   = r_press;
  assign release_tick = r_release;
  assign long_tick    = r_long;
  assign held         = r_held;

  // Release is tested before any terminal count so it always wins that cycle.
  always_ff @(posedge reloj) begin
    if (!resetM) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_press   <= 1'b0;
      r_release <= 1'b0;
      r_long    <= 1'b0;
      r_held    <= 1'b0;
`ifdef KEY_REPEAT_EN
      r_repeat  <= 1'b0;
`endif
    end else begin
      r_press   <= 1'b0;
      r_release <= 1'b0;
      r_long    <= 1'b0;
`ifdef KEY_REPEAT_EN
      r_repeat  <= 1'b0;
`endif
      unique case (r_state)
        IDLE: begin
          if (sw_db) begin
            r_state <= PRESSED;
            r_cnt   <= '0;
            r_press <= 1'b1;
          end
        end
        PRESSED: begin
          if (!sw_db) begin
            r_state   <= IDLE;
            r_cnt     <= '0;
            r_release <= 1'b1;
          end else if (r_cnt == LONG_LAST) begin
            r_state <= HELD;
            r_cnt   <= '0;
            r_long  <= 1'b1;
            r_held  <= 1'b1;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        HELD: begin
          if (!sw_db) begin
            r_state   <= IDLE;
            r_cnt     <= '0;
            r_release <= 1'b1;
            r_held    <= 1'b0;
          end
`ifdef KEY_REPEAT_EN
          else if (r_cnt == REPEAT_LAST) begin
            r_cnt    <= '0;
            r_repeat <= 1'b1;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
`endif
        end
        default: begin
          r_state <= IDLE;
          r_cnt   <= '0;
          r_held  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_key_event_decoder.sv
// Randomized bench for key_event_decoder with a press-duration reference model.
module tb_key_event_decoder;

  localparam int LONG   = 8;
  localparam int REPEAT = 4;

  logic reloj = 1'b0;
  logic resetM;
  logic sw_db;
  logic press_tick, release_tick, long_tick, repeat_tick, held;
  logic [4:0] dut_o;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: a press lasts m_run extra cycles beyond the press edge.
  bit         m_active = 1'b0;
  int         m_run    = 0;
  logic [4:0] exp_o    = '0;

  key_event_decoder #(
    .LONG_CYCLES  (LONG),
    .REPEAT_CYCLES(REPEAT),
    .CW           (4)
  ) dut (
    .reloj       (reloj),
    .resetM      (resetM),
    .sw_db       (sw_db),
    .press_tick  (press_tick),
    .release_tick(release_tick),
    .long_tick   (long_tick),
    .repeat_tick (repeat_tick),
    .held        (held)
  );

  assign dut_o = {press_tick, release_tick, long_tick, repeat_tick, held};

  always #5 reloj = ~reloj;

  // Drive one cycle, advance the model for that edge, then settle past the edge.
  task automatic drive(input logic s, input logic rst_n);
    sw_db  = s;
    resetM = rst_n;
    @(posedge reloj);
    exp_o = '0;
    if (!rst_n) begin
      m_active = 1'b0;
      m_run    = 0;
    end else if (!m_active) begin
      if (s) begin
        m_active = 1'b1;
        m_run    = 0;
        exp_o[4] = 1'b1;
      end
    end else if (!s) begin
      m_active = 1'b0;
      exp_o[3] = 1'b1;
    end else begin
      m_run++;
      if (m_run == LONG) exp_o[2] = 1'b1;
`ifdef KEY_REPEAT_EN
      else if (m_run > LONG && (m_run - LONG) % REPEAT == 0) exp_o[1] = 1'b1;
`endif
      exp_o[0] = (m_run >= LONG);
    end
    #1;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) begin
      drive(1'($urandom_range(0, 1)), 1'b0);
      n_tests++;
      if (dut_o !== 5'b00000) begin
        n_fail++;
        $display("FAIL reset[%0d]: outputs %b, expected 00000", i, dut_o);
      end
    end
    drive(1'b0, 1'b1);
    n_tests++;
    if (dut_o !== 5'b00000) begin
      n_fail++;
      $display("FAIL reset_idle: outputs %b, expected 00000", dut_o);
    end
  endtask

  task automatic test_short_press();
    logic [4:0] want [0:5];
    want = '{5'b10000, 5'b00000, 5'b00000, 5'b01000, 5'b00000, 5'b00000};
    for (int i = 0; i < 6; i++) begin
      drive((i < 3) ? 1'b1 : 1'b0, 1'b1);
      n_tests++;
      if (dut_o !== want[i] || dut_o !== exp_o) begin
        n_fail++;
        $display("FAIL short_press[%0d]: outputs %b, expected %b (model %b)", i, dut_o, want[i], exp_o);
      end
    end
  endtask

  task automatic test_long_hold();
    int press_at = -1, long_at = -1, n_rep = 0, want_rep;
`ifdef KEY_REPEAT_EN
    want_rep = 2;
`else
    want_rep = 0;
`endif
    for (int i = 0; i < 20; i++) begin
      drive(1'b1, 1'b1);
      if (press_tick) press_at = i;
      if (long_tick) long_at = i;
      if (repeat_tick) n_rep++;
      n_tests++;
      if (dut_o !== exp_o) begin
        n_fail++;
        $display("FAIL long_hold[%0d]: outputs %b, expected %b", i, dut_o, exp_o);
      end
    end
    n_tests++;
    if (long_at - press_at !== LONG || held !== 1'b1) begin
      n_fail++;
      $display("FAIL long_distance: press@%0d long@%0d held=%b, expected distance %0d held=1",
               press_at, long_at, held, LONG);
    end
    n_tests++;
    if (n_rep !== want_rep) begin
      n_fail++;
      $display("FAIL repeat_count: got %0d, expected %0d", n_rep, want_rep);
    end
    drive(1'b0, 1'b1);
    n_tests++;
    if (dut_o !== 5'b01000) begin
      n_fail++;
      $display("FAIL long_release: outputs %b, expected 01000", dut_o);
    end
    drive(1'b0, 1'b1);
  endtask

  task automatic test_terminal_release();
    for (int i = 0; i < LONG; i++) drive(1'b1, 1'b1);
    drive(1'b0, 1'b1);
    n_tests++;
    if (dut_o !== 5'b01000 || dut_o !== exp_o) begin
      n_fail++;
      $display("FAIL terminal_release: outputs %b, expected 01000 (model %b)", dut_o, exp_o);
    end
    drive(1'b0, 1'b1);
    n_tests++;
    if (dut_o !== 5'b00000) begin
      n_fail++;
      $display("FAIL terminal_after: outputs %b, expected 00000", dut_o);
    end
  endtask

  task automatic test_reset_mid_hold();
    for (int i = 0; i < LONG + 3; i++) drive(1'b1, 1'b1);
    n_tests++;
    if (held !== 1'b1) begin
      n_fail++;
      $display("FAIL mid_hold_held: held %b, expected 1", held);
    end
    drive(1'b1, 1'b0);
    n_tests++;
    if (dut_o !== 5'b00000) begin
      n_fail++;
      $display("FAIL mid_hold_reset: outputs %b, expected 00000", dut_o);
    end
    drive(1'b1, 1'b1);
    n_tests++;
    if (dut_o !== 5'b10000 || dut_o !== exp_o) begin
      n_fail++;
      $display("FAIL mid_hold_repress: outputs %b, expected 10000 (model %b)", dut_o, exp_o);
    end
    drive(1'b0, 1'b1);
    drive(1'b0, 1'b1);
  endtask

  task automatic test_random();
    int n_press = 0, n_rel = 0, n_multi = 0, n_bad = 0, cyc = 0;
    logic lvl = 1'b0;
    while (cyc < 10000) begin
      int len = $urandom_range(1, 30);
      lvl = ~lvl;
      for (int k = 0; k < len && cyc < 10000; k++) begin
        drive(lvl, 1'b1);
        cyc++;
        n_press += int'(press_tick);
        n_rel   += int'(release_tick);
        if ($countones(dut_o[4:1]) > 1) n_multi++;
        if (dut_o !== exp_o) begin
          n_bad++;
          if (n_bad <= 5)
            $display("FAIL random[%0d]: outputs %b, expected %b", cyc, dut_o, exp_o);
        end
      end
    end
    n_tests++;
    if (n_bad != 0) n_fail++;
    n_tests++;
    if (n_multi != 0) begin
      n_fail++;
      $display("FAIL exclusivity: %0d cycles with multiple ticks, expected 0", n_multi);
    end
    n_tests++;
    if (n_press - n_rel > 1 || n_rel - n_press > 1 || n_press == 0) begin
      n_fail++;
      $display("FAIL press_release_balance: press %0d release %0d, expected within 1", n_press, n_rel);
    end
  endtask

  initial begin
    sw_db  = 1'b0;
    resetM = 1'b0;
    #2;
    test_reset();
    test_short_press();
    test_long_hold();
    test_terminal_release();
    test_reset_mid_hold();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
